cp0_exception_unit: RTL

- Coprocessor-0 block for the P8 pipeline. Sits downstream of the memory-stage address exception detector and beside the M-stage pipeline register.
- Merges the 2-bit memory address exception, the pipeline's other exception codes and the device interrupt lines into a single exception request.
- Holds SR/Cause/EPC/PRId (and BadVAddr when enabled), services mfc0/mtc0 and implements eret.

---
 rtl/cp0_exception_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 SR/Cause/EPC/PRId with exception/interrupt merge, mfc0/mtc0, eret
// Optional BadVAddr (reg 8) when BADVADDR_EN is defined.
module cp0_exception_unit #(
    parameter logic [31:0] PRID = 32'h4650_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [1:0]  mem_exc,
    input  logic [4:0]  exc_code,
    input  logic [31:0] bad_addr,
    input  logic [5:0]  hw_int,
    input  logic        we,
    input  logic [4:0]  sel,
    input  logic [31:0] din,
    input  logic        eret,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        int_req,
    output logic        exl
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        mem_valid;
    logic [4:0]  mem_code;
    logic        irq;
    logic        exc;
    logic [4:0]  next_code;
    logic [31:0] epc_base;
    logic [31:0] epc_next;

    // mem_exc 01 is reserved and behaves as no memory exception
    assign mem_valid = mem_exc[1];
    assign mem_code  = mem_exc[0] ? 5'd5 : 5'd4;

    assign irq       = sr_ie & ~sr_exl & (|(hw_int & sr_im));
    assign exc       = ~sr_exl & (mem_valid | (exc_code != 5'd0));
    assign int_req   = irq | exc;
    assign next_code = irq ? 5'd0 : (mem_valid ? mem_code : exc_code);

    assign epc_base  = {pc[31:2], 2'b00};
    assign epc_next  = bd ? epc_base - 32'd4 : epc_base;

    assign epc_out   = epc;
    assign exl       = sr_exl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_int;
            if (int_req) begin
                // exception entry wins over any same-cycle mtc0
                sr_exl    <= 1'b1;
                cause_exc <= next_code;
                cause_bd  <= bd;
                epc       <= epc_next;
            end else begin
                if (we && sel == 5'd12) begin
                    sr_im  <= din[15:10];
                    sr_exl <= din[1];
                    sr_ie  <= din[0];
                end
                if (we && sel == 5'd14) begin
                    epc <= {din[31:2], 2'b00};
                end
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

`ifdef BADVADDR_EN
    logic [31:0] badvaddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            badvaddr <= 32'd0;
        end else if (int_req && !irq && mem_valid) begin
            badvaddr <= bad_addr;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, din[1:0], pc[1:0]};
`else
    logic [31:0] badvaddr;
    assign badvaddr = 32'd0;

    logic unused_bits;
    assign unused_bits = &{1'b0, din[1:0], pc[1:0], bad_addr};
`endif

    always_comb begin
        dout = 32'd0;
        case (sel)
            5'd8:    dout = badvaddr;
            5'd12:   dout = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            5'd13:   dout = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'b00};
            5'd14:   dout = epc;
            5'd15:   dout = PRID;
            default: dout = 32'd0;
        endcase
    end

endmodule
